// File: rtl/pipe_ex_stage.sv
// Execute stage: operand forwarding, ALU, optional serial shifter, branch/jump resolution
// with a one-cycle redirect and predictor-update pulse on entry to HOLD.
module pipe_ex_stage #(
   parameter int XLEN         = 32,
   parameter int FWD_N        = 2,
   parameter int BP_TAG_W     = 10,
   parameter int SHIFT_SERIAL = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [1:0]            in_cls,
   input  logic [3:0]            in_op,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [XLEN-1:0]       in_opr1,
   input  logic [XLEN-1:0]       in_opr2,
   input  logic [XLEN-1:0]       in_imm,
   input  logic                  in_wb_e,
   input  logic [1:0]            in_mem_e,
   input  logic [1:0]            in_mem_len,
   input  logic                  in_pred_taken,
   input  logic [FWD_N-1:0]      fwd_vld,
   input  logic [5*FWD_N-1:0]    fwd_idx,
   input  logic [XLEN*FWD_N-1:0] fwd_val,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_ans,
   output logic [XLEN-1:0]       out_sdata,
   output logic [4:0]            out_rd,
   output logic                  out_wb_e,
   output logic [1:0]            out_mem_e,
   output logic [1:0]            out_mem_len,
   output logic [4:0]            ex_fwd_idx,
   output logic [XLEN-1:0]       ex_fwd_val,
   output logic                  redir_valid,
   output logic [XLEN-1:0]       redir_pc,
   output logic                  bp_we,
   output logic [BP_TAG_W-1:0]   bp_tag,
   output logic                  bp_taken
);

   localparam logic [1:0] CLS_ALU = 2'b00;
   localparam logic [1:0] CLS_BR  = 2'b01;
   localparam logic [1:0] CLS_JMP = 2'b10;
   localparam logic [1:0] CLS_MEM = 2'b11;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;
   typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} sh_op_e;

   state_e                state_q, state_d;
   sh_op_e                sh_op_q, sh_op_d;
   logic [XLEN-1:0]       ans_q, ans_d, sdata_q, sdata_d, redir_pc_q, redir_pc_d;
   logic [4:0]            rd_q, rd_d, cnt_q, cnt_d;
   logic                  wb_e_q, wb_e_d;
   logic [1:0]            mem_e_q, mem_e_d, mem_len_q, mem_len_d;
   logic                  redir_valid_q, redir_valid_d, bp_we_q, bp_we_d, bp_taken_q, bp_taken_d;
   logic [BP_TAG_W-1:0]   bp_tag_q, bp_tag_d;

   logic [XLEN-1:0]       opr1, opr2, alu_res;
   logic [4:0]            shamt;
   logic                  accept, br_taken, serial_start;

   // Descending scan so the lowest (youngest) matching source is the one that sticks.
   function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]            rs,
                                               input logic [XLEN-1:0]       rf_val,
                                               input logic [FWD_N-1:0]      vld,
                                               input logic [5*FWD_N-1:0]    idx,
                                               input logic [XLEN*FWD_N-1:0] val);
      fwd_sel = rf_val;
      if (rs != 5'd0) begin
         for (int k = FWD_N - 1; k >= 0; k--) begin
            if (vld[k] && idx[5*k +: 5] == rs) fwd_sel = val[XLEN*k +: XLEN];
         end
      end
   endfunction

   assign opr1  = fwd_sel(in_rs1, in_opr1, fwd_vld, fwd_idx, fwd_val);
   assign opr2  = fwd_sel(in_rs2, in_opr2, fwd_vld, fwd_idx, fwd_val);
   assign shamt = opr2[4:0];

   assign in_ready = rst_n && !flush && (state_q == IDLE || (state_q == HOLD && out_ready));
   assign accept   = in_valid && in_ready;

   assign serial_start = (SHIFT_SERIAL != 0) && in_cls == CLS_ALU && shamt != 5'd0 &&
                         (in_op == 4'd2 || in_op == 4'd6 || in_op == 4'd7);

   always_comb begin
      case (in_op)
         4'd0:    alu_res = opr1 + opr2;
         4'd1:    alu_res = opr1 - opr2;
         4'd2:    alu_res = opr1 << shamt;
         4'd3:    alu_res = XLEN'($signed(opr1) < $signed(opr2));
         4'd4:    alu_res = XLEN'(opr1 < opr2);
         4'd5:    alu_res = opr1 ^ opr2;
         4'd6:    alu_res = opr1 >> shamt;
         4'd7:    alu_res = XLEN'($signed(opr1) >>> shamt);
         4'd8:    alu_res = opr1 | opr2;
         4'd9:    alu_res = opr1 & opr2;
         4'd10:   alu_res = opr2;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (in_op)
         4'd0:    br_taken = (opr1 == opr2);
         4'd1:    br_taken = (opr1 != opr2);
         4'd4:    br_taken = ($signed(opr1) <  $signed(opr2));
         4'd5:    br_taken = ($signed(opr1) >= $signed(opr2));
         4'd6:    br_taken = (opr1 <  opr2);
         4'd7:    br_taken = (opr1 >= opr2);
         default: br_taken = 1'b0;
      endcase
   end

   // NOTE: every signal gets a default first, so no path through this block infers a latch.
   always_comb begin
      state_d       = state_q;
      sh_op_d       = sh_op_q;
      ans_d         = ans_q;
      sdata_d       = sdata_q;
      rd_d          = rd_q;
      cnt_d         = cnt_q;
      wb_e_d        = wb_e_q;
      mem_e_d       = mem_e_q;
      mem_len_d     = mem_len_q;
      redir_pc_d    = redir_pc_q;
      bp_tag_d      = bp_tag_q;
      bp_taken_d    = bp_taken_q;
      redir_valid_d = 1'b0;
      bp_we_d       = 1'b0;

      case (state_q)
         BUSY: begin
            case (sh_op_q)
               SH_SRL:  ans_d = ans_q >> 1;
               SH_SRA:  ans_d = {ans_q[XLEN-1], ans_q[XLEN-1:1]};
               default: ans_d = ans_q << 1;
            endcase
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = HOLD;
         end
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d   = serial_start ? BUSY : HOLD;
         rd_d      = in_rd;
         wb_e_d    = in_wb_e;
         mem_e_d   = in_mem_e;
         mem_len_d = in_mem_len;
         sdata_d   = opr2;
         cnt_d     = shamt;
         case (in_op)
            4'd6:    sh_op_d = SH_SRL;
            4'd7:    sh_op_d = SH_SRA;
            default: sh_op_d = SH_SLL;
         endcase
         case (in_cls)
            CLS_ALU: ans_d = serial_start ? opr1 : alu_res;
            CLS_BR: begin
               ans_d         = '0;
               wb_e_d        = 1'b0;
               bp_we_d       = 1'b1;
               bp_taken_d    = br_taken;
               bp_tag_d      = in_pc[BP_TAG_W-1:0];
               redir_valid_d = (br_taken != in_pred_taken);
               redir_pc_d    = br_taken ? in_pc + in_imm : in_pc + XLEN'(4);
            end
            CLS_JMP: begin
               ans_d         = in_pc + XLEN'(4);
               redir_valid_d = 1'b1;
               redir_pc_d    = (opr1 + in_imm) & ~XLEN'(1);
            end
            default: ans_d = opr1 + in_imm;
         endcase
      end

      if (flush) state_d = IDLE;
   end

   // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sh_op_q       <= SH_SLL;
         ans_q         <= '0;
         sdata_q       <= '0;
         rd_q          <= '0;
         cnt_q         <= '0;
         wb_e_q        <= 1'b0;
         mem_e_q       <= '0;
         mem_len_q     <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         bp_we_q       <= 1'b0;
         bp_tag_q      <= '0;
         bp_taken_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         sh_op_q       <= sh_op_d;
         ans_q         <= ans_d;
         sdata_q       <= sdata_d;
         rd_q          <= rd_d;
         cnt_q         <= cnt_d;
         wb_e_q        <= wb_e_d;
         mem_e_q       <= mem_e_d;
         mem_len_q     <= mem_len_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         bp_we_q       <= bp_we_d;
         bp_tag_q      <= bp_tag_d;
         bp_taken_q    <= bp_taken_d;
      end
   end

   assign out_valid   = (state_q == HOLD);
   assign out_ans     = ans_q;
   assign out_sdata   = sdata_q;
   assign out_rd      = rd_q;
   assign out_wb_e    = wb_e_q;
   assign out_mem_e   = mem_e_q;
   assign out_mem_len = mem_len_q;
   assign ex_fwd_idx  = (out_valid && wb_e_q && mem_e_q == 2'b00) ? rd_q : 5'd0;
   assign ex_fwd_val  = ans_q;
   assign redir_valid = redir_valid_q;
   assign redir_pc    = redir_pc_q;
   assign bp_we       = bp_we_q;
   assign bp_tag      = bp_tag_q;
   assign bp_taken    = bp_taken_q;

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Bench for pipe_ex_stage: directed scenarios plus randomized traffic against a
// behavioural model; a second instance exercises the serial shifter.
module tb_pipe_ex_stage;
   localparam int XLEN = 32, FWD_N = 2, BP_TAG_W = 10;

   logic clk = 1'b0;
   logic rst_n, flush, in_valid, in_ready, out_ready;
   logic [XLEN-1:0] in_pc, in_opr1, in_opr2, in_imm;
   logic [1:0] in_cls, in_mem_e, in_mem_len;
   logic [3:0] in_op;
   logic [4:0] in_rd, in_rs1, in_rs2;
   logic in_wb_e, in_pred_taken;
   logic [FWD_N-1:0] fwd_vld;
   logic [5*FWD_N-1:0] fwd_idx;
   logic [XLEN*FWD_N-1:0] fwd_val;

   logic out_valid, out_wb_e, redir_valid, bp_we, bp_taken;
   logic [XLEN-1:0] out_ans, out_sdata, ex_fwd_val, redir_pc;
   logic [4:0] out_rd, ex_fwd_idx;
   logic [1:0] out_mem_e, out_mem_len;
   logic [BP_TAG_W-1:0] bp_tag;

   logic s_in_ready, s_out_valid, s_out_wb_e, s_redir_valid, s_bp_we, s_bp_taken;
   logic [XLEN-1:0] s_out_ans, s_out_sdata, s_ex_fwd_val, s_redir_pc;
   logic [4:0] s_out_rd, s_ex_fwd_idx;
   logic [1:0] s_out_mem_e, s_out_mem_len;
   logic [BP_TAG_W-1:0] s_bp_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ex_stage #(.XLEN(XLEN), .FWD_N(FWD_N), .BP_TAG_W(BP_TAG_W), .SHIFT_SERIAL(0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_cls(in_cls), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_opr1(in_opr1), .in_opr2(in_opr2), .in_imm(in_imm),
      .in_wb_e(in_wb_e), .in_mem_e(in_mem_e), .in_mem_len(in_mem_len),
      .in_pred_taken(in_pred_taken), .fwd_vld(fwd_vld), .fwd_idx(fwd_idx), .fwd_val(fwd_val),
      .out_valid(out_valid), .out_ready(out_ready), .out_ans(out_ans), .out_sdata(out_sdata),
      .out_rd(out_rd), .out_wb_e(out_wb_e), .out_mem_e(out_mem_e), .out_mem_len(out_mem_len),
      .ex_fwd_idx(ex_fwd_idx), .ex_fwd_val(ex_fwd_val), .redir_valid(redir_valid),
      .redir_pc(redir_pc), .bp_we(bp_we), .bp_tag(bp_tag), .bp_taken(bp_taken));

   pipe_ex_stage #(.XLEN(XLEN), .FWD_N(FWD_N), .BP_TAG_W(BP_TAG_W), .SHIFT_SERIAL(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_pc(in_pc), .in_cls(in_cls), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_opr1(in_opr1), .in_opr2(in_opr2), .in_imm(in_imm),
      .in_wb_e(in_wb_e), .in_mem_e(in_mem_e), .in_mem_len(in_mem_len),
      .in_pred_taken(in_pred_taken), .fwd_vld(fwd_vld), .fwd_idx(fwd_idx), .fwd_val(fwd_val),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_ans(s_out_ans),
      .out_sdata(s_out_sdata), .out_rd(s_out_rd), .out_wb_e(s_out_wb_e),
      .out_mem_e(s_out_mem_e), .out_mem_len(s_out_mem_len), .ex_fwd_idx(s_ex_fwd_idx),
      .ex_fwd_val(s_ex_fwd_val), .redir_valid(s_redir_valid), .redir_pc(s_redir_pc),
      .bp_we(s_bp_we), .bp_tag(s_bp_tag), .bp_taken(s_bp_taken));

   typedef struct {
      logic [31:0] pc, opr1, opr2, imm;
      logic [1:0]  cls, mem_e, mem_len;
      logic [3:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic        wb_e, pred;
   } instr_t;

   typedef struct packed {
      logic [31:0] ans;
      logic [31:0] sdata;
      logic [4:0]  rd;
      logic        wb_e;
      logic [1:0]  mem_e;
      logic [1:0]  mem_len;
   } res_t;

   typedef struct packed {
      logic        redir;
      logic [31:0] redir_pc;
      logic        bp_we;
      logic [9:0]  bp_tag;
      logic        bp_taken;
   } pul_t;

   function automatic instr_t mk(input logic [1:0] cls, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
      instr_t i;
      i.pc = '0; i.cls = cls; i.op = op; i.rd = '0; i.rs1 = '0; i.rs2 = '0;
      i.opr1 = a; i.opr2 = b; i.imm = '0; i.wb_e = 1'b0; i.mem_e = '0; i.mem_len = '0;
      i.pred = 1'b0;
      return i;
   endfunction

   task automatic apply(input instr_t i);
      in_pc = i.pc; in_cls = i.cls; in_op = i.op; in_rd = i.rd; in_rs1 = i.rs1;
      in_rs2 = i.rs2; in_opr1 = i.opr1; in_opr2 = i.opr2; in_imm = i.imm;
      in_wb_e = i.wb_e; in_mem_e = i.mem_e; in_mem_len = i.mem_len; in_pred_taken = i.pred;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; flush = 1'b0; fwd_vld = '0; fwd_idx = '0; fwd_val = '0;
      apply(mk(2'd0, 4'd0, 32'd0, 32'd0));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference operand source: first valid forwarding slot (youngest first) naming rs.
   function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] rf_val);
      if (rs == 5'd0) return rf_val;
      for (int k = 0; k < FWD_N; k++)
         if (fwd_vld[k] && fwd_idx[5*k +: 5] == rs) return fwd_val[32*k +: 32];
      return rf_val;
   endfunction

   function automatic void model(input instr_t i, output res_t r, output pul_t p);
      logic [31:0] a, b, tgt;
      logic [4:0]  sh;
      logic        t;
      a = pick(i.rs1, i.opr1);
      b = pick(i.rs2, i.opr2);
      sh = b[4:0];
      r = '0; p = '0;
      r.rd = i.rd; r.wb_e = i.wb_e; r.mem_e = i.mem_e; r.mem_len = i.mem_len;
      case (i.cls)
         2'd0: case (i.op)
            4'd0: r.ans = a + b;
            4'd1: r.ans = a - b;
            4'd2: r.ans = a << sh;
            4'd3: r.ans = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r.ans = (a < b) ? 32'd1 : 32'd0;
            4'd5: r.ans = a ^ b;
            4'd6: r.ans = a >> sh;
            4'd7: r.ans = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd8: r.ans = a | b;
            4'd9: r.ans = a & b;
            4'd10: r.ans = b;
            default: r.ans = 32'd0;
         endcase
         2'd1: begin
            case (i.op)
               4'd0: t = (a == b);
               4'd1: t = (a != b);
               4'd4: t = ($signed(a) < $signed(b));
               4'd5: t = !($signed(a) < $signed(b));
               4'd6: t = (a < b);
               4'd7: t = !(a < b);
               default: t = 1'b0;
            endcase
            r.wb_e = 1'b0;
            p.bp_we = 1'b1; p.bp_taken = t; p.bp_tag = i.pc[9:0];
            p.redir = (t != i.pred);
            if (p.redir) p.redir_pc = t ? i.pc + i.imm : i.pc + 32'd4;
         end
         2'd2: begin
            r.ans = i.pc + 32'd4;
            tgt = a + i.imm;
            tgt[0] = 1'b0;
            p.redir = 1'b1; p.redir_pc = tgt;
         end
         default: begin
            r.ans = a + i.imm;
            r.sdata = b;
         end
      endcase
   endfunction

   function automatic res_t obs_res(input logic is_mem);
      res_t r;
      r.ans = out_ans; r.sdata = is_mem ? out_sdata : 32'd0; r.rd = out_rd;
      r.wb_e = out_wb_e; r.mem_e = out_mem_e; r.mem_len = out_mem_len;
      return r;
   endfunction

   function automatic pul_t obs_pul();
      pul_t p;
      p.redir = redir_valid; p.redir_pc = redir_valid ? redir_pc : 32'd0;
      p.bp_we = bp_we; p.bp_tag = bp_we ? bp_tag : 10'd0; p.bp_taken = bp_we ? bp_taken : 1'b0;
      return p;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; idle_inputs(); in_valid = 1'b1; out_ready = 1'b1;
      step(); step();
      checks++;
      if (in_ready !== 1'b0 || s_in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready, s_in_ready);
      end
      checks++;
      if ({out_valid, out_ans, out_sdata, out_rd, out_wb_e, out_mem_e, out_mem_len, ex_fwd_idx,
           ex_fwd_val, redir_valid, redir_pc, bp_we, bp_tag, bp_taken, s_out_valid, s_out_ans,
           s_out_sdata, s_out_rd, s_out_wb_e, s_out_mem_e, s_out_mem_len, s_ex_fwd_idx,
           s_ex_fwd_val, s_redir_valid, s_redir_pc, s_bp_we, s_bp_tag, s_bp_taken} !== '0) begin
         errors++; $display("FAIL reset_outputs: some output nonzero, want all 0");
      end
      in_valid = 1'b0; rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add();
      instr_t i;
      i = mk(2'd0, 4'd0, 32'd5, 32'd7); i.rd = 5'd4; i.wb_e = 1'b1;
      apply(i); in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", in_ready); end
      step(); in_valid = 1'b0;
      checks++;
      if ({out_valid, out_ans, ex_fwd_idx, in_ready} !== {1'b1, 32'd12, 5'd4, 1'b1}) begin
         errors++;
         $display("FAIL add_result: got v=%b ans=%0d fwd=%0d rdy=%b want v=1 ans=12 fwd=4 rdy=1",
                  out_valid, out_ans, ex_fwd_idx, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_forwarding();
      logic [1:0] t_vld [6] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01};
      int t_idx0 [6] = '{3, 3, 3, 5, 0, 3};
      int t_idx1 [6] = '{3, 3, 3, 3, 0, 9};
      int t_rs1  [6] = '{3, 3, 3, 3, 0, 0};
      int t_rs2  [6] = '{0, 0, 0, 0, 0, 3};
      int t_opr1 [6] = '{50, 50, 50, 50, 50, 500};
      int t_opr2 [6] = '{1, 1, 1, 1, 1, 7};
      int t_exp  [6] = '{99, 199, 49, 199, 49, 400};
      instr_t i;
      for (int n = 0; n < 6; n++) begin
         i = mk(2'd0, 4'd1, 32'(t_opr1[n]), 32'(t_opr2[n]));
         i.rs1 = 5'(t_rs1[n]); i.rs2 = 5'(t_rs2[n]);
         apply(i);
         fwd_vld = t_vld[n];
         fwd_idx = {5'(t_idx1[n]), 5'(t_idx0[n])};
         fwd_val = {32'd200, 32'd100};
         in_valid = 1'b1;
         step();
         in_valid = 1'b0; fwd_vld = '0;
         checks++;
         if (out_ans !== 32'(t_exp[n])) begin
            errors++; $display("FAIL fwd_case%0d: got %0d want %0d", n, out_ans, t_exp[n]);
         end
         step();
      end
   endtask

   task automatic test_branch_stall();
      instr_t i;
      pul_t   p;
      i = mk(2'd1, 4'd0, 32'd4, 32'd4); i.pc = 32'h100; i.imm = 32'h20; i.rd = 5'd7; i.wb_e = 1'b1;
      apply(i); in_valid = 1'b1; out_ready = 1'b0;
      step();
      i = mk(2'd0, 4'd0, 32'd1, 32'd1);
      apply(i);
      p = obs_pul();
      checks++;
      if (p !== {1'b1, 32'h120, 1'b1, 10'h100, 1'b1}) begin
         errors++; $display("FAIL beq_pulse: got %h want %h", p, {1'b1, 32'h120, 1'b1, 10'h100, 1'b1});
      end
      checks++;
      if ({out_valid, out_ans, out_wb_e, ex_fwd_idx} !== {1'b1, 32'd0, 1'b0, 5'd0}) begin
         errors++; $display("FAIL beq_result: got v=%b ans=%h wb=%b fwd=%0d want 1/0/0/0",
                            out_valid, out_ans, out_wb_e, ex_fwd_idx);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if ({out_valid, out_ans, redir_valid, bp_we, in_ready} !== {1'b1, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL stall_cycle%0d: got v=%b ans=%h redir=%b bpwe=%b rdy=%b want 1/0/0/0/0",
                               c, out_valid, out_ans, redir_valid, bp_we, in_ready);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
      step();
      i = mk(2'd2, 4'd0, 32'h1001, 32'd0); i.pc = 32'h200; i.imm = 32'h10; i.rd = 5'd1; i.wb_e = 1'b1;
      apply(i);
      checks++;
      if ({out_valid, out_ans, redir_valid, bp_we} !== {1'b1, 32'd2, 1'b0, 1'b0}) begin
         errors++; $display("FAIL b2b_add: got v=%b ans=%0d redir=%b bpwe=%b want 1/2/0/0",
                            out_valid, out_ans, redir_valid, bp_we);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_ans, ex_fwd_idx, obs_pul()} !== {32'h204, 5'd1, 1'b1, 32'h1010, 1'b0, 10'd0, 1'b0}) begin
         errors++; $display("FAIL jalr: got ans=%h fwd=%0d pul=%h want ans=204 fwd=1 redir to 1010",
                            out_ans, ex_fwd_idx, obs_pul());
      end
      step();
   endtask

   task automatic test_flush();
      instr_t i;
      i = mk(2'd0, 4'd0, 32'd1, 32'd2);
      apply(i); in_valid = 1'b1; out_ready = 1'b0;
      step();
      i = mk(2'd0, 4'd0, 32'd10, 32'd10);
      apply(i); flush = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         errors++; $display("FAIL flush_pre: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
      end
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b want 0", out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept: got %b want 0", out_valid); end
   endtask

   task automatic test_serial_shift();
      logic [3:0]  t_op  [4] = '{4'd2, 4'd7, 4'd6, 4'd2};
      logic [31:0] t_a   [4] = '{32'd1, 32'h8000_0000, 32'h8000_0000, 32'd3};
      int          t_sh  [4] = '{5, 4, 31, 0};
      logic [31:0] t_exp [4] = '{32'd32, 32'hF800_0000, 32'd1, 32'd3};
      instr_t i;
      out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         apply(mk(2'd0, t_op[n], t_a[n], 32'(t_sh[n])));
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         for (int c = 0; c < t_sh[n]; c++) begin
            checks++;
            if ({s_in_ready, s_out_valid} !== 2'b00) begin
               errors++; $display("FAIL serial%0d_busy%0d: got rdy=%b v=%b want 0/0",
                                  n, c, s_in_ready, s_out_valid);
            end
            step();
         end
         checks++;
         if ({s_out_valid, s_out_ans} !== {1'b1, t_exp[n]}) begin
            errors++; $display("FAIL serial%0d_result: got v=%b ans=%h want v=1 ans=%h",
                               n, s_out_valid, s_out_ans, t_exp[n]);
         end
         step();
      end
      i = mk(2'd0, 4'd2, 32'd1, 32'd10);
      apply(i); in_valid = 1'b1;
      step(); in_valid = 1'b0;
      step(); step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_out_valid, s_in_ready, s_redir_valid, s_bp_we} !== 4'b0000) begin
         errors++; $display("FAIL serial_reset: got v=%b rdy=%b redir=%b bpwe=%b want all 0",
                            s_out_valid, s_in_ready, s_redir_valid, s_bp_we);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if ({s_out_valid, s_in_ready} !== 2'b01) begin
         errors++; $display("FAIL serial_after_reset: got v=%b rdy=%b want 0/1", s_out_valid, s_in_ready);
      end
   endtask

   task automatic test_random();
      instr_t i;
      res_t   mr;
      pul_t   mp, ep;
      logic   mv = 1'b0, mjust = 1'b0, m_mem = 1'b0, exp_ready;
      for (int cyc = 0; cyc < 600; cyc++) begin
         checks++;
         if (out_valid !== mv) begin
            errors++; $display("FAIL rand%0d_valid: got %b want %b", cyc, out_valid, mv);
         end
         if (mv) begin
            checks++;
            if (obs_res(m_mem) !== mr || ex_fwd_val !== mr.ans) begin
               errors++; $display("FAIL rand%0d_result: got %h want %h", cyc, obs_res(m_mem), mr);
            end
            checks++;
            if (ex_fwd_idx !== ((mr.wb_e && mr.mem_e == 2'b00) ? mr.rd : 5'd0)) begin
               errors++; $display("FAIL rand%0d_fwdidx: got %0d rd=%0d", cyc, ex_fwd_idx, mr.rd);
            end
         end
         ep = mjust ? mp : '0;
         checks++;
         if (obs_pul() !== ep) begin
            errors++; $display("FAIL rand%0d_pulse: got %h want %h", cyc, obs_pul(), ep);
         end

         i.cls = 2'($urandom_range(3)); i.op = 4'($urandom_range(15));
         i.rd = 5'($urandom_range(7)); i.rs1 = 5'($urandom_range(7)); i.rs2 = 5'($urandom_range(7));
         i.opr1 = $urandom;
         i.opr2 = ($urandom_range(3) == 0) ? i.opr1 : (($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(40)));
         i.pc = $urandom & ~32'd3; i.imm = $urandom; i.wb_e = 1'($urandom_range(1));
         i.mem_e = 2'($urandom_range(3)); i.mem_len = 2'($urandom_range(3)); i.pred = 1'($urandom_range(1));
         apply(i);
         fwd_vld = 2'($urandom_range(3));
         fwd_idx = {5'($urandom_range(7)), 5'($urandom_range(7))};
         fwd_val = {$urandom, $urandom};
         in_valid = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         flush = ($urandom_range(15) == 0);
         #1;
         exp_ready = !flush && (!mv || out_ready);
         checks++;
         if (in_ready !== exp_ready) begin
            errors++; $display("FAIL rand%0d_ready: got %b want %b", cyc, in_ready, exp_ready);
         end
         if (in_valid && exp_ready) begin
            model(i, mr, mp);
            mv = 1'b1; mjust = 1'b1; m_mem = (i.cls == 2'd3);
         end else begin
            mjust = 1'b0;
            if (flush || out_ready) mv = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      idle_inputs(); out_ready = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_forwarding();
      test_branch_stall();
      test_flush();
      test_serial_shift();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
